bbox_bin_accumulator: RTL and testbench

BBOX_BIN_ACCUMULATOR -- requirements
Module: bbox_bin_accumulator

---
 rtl/bbox_bin_accumulator_pkg.sv | 15 +
 rtl/bbox_bin_accumulator_if.sv | 29 ++
 rtl/bbox_bin_accumulator_bin_ram.sv | 24 ++
 rtl/bbox_bin_accumulator.sv | 165 ++++++++++++++++
 tb/tb_bbox_bin_accumulator.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bbox_bin_accumulator_pkg.sv
// Shared types and default sizing for the bounding-box bin accumulator.
package bbox_bin_accumulator_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH  = 8;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } state_t;

endpackage

// File: rtl/bbox_bin_accumulator_if.sv
// Index input stream and dump output stream of the bin accumulator.
interface bbox_bin_accumulator_if
  import bbox_bin_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);

  logic signed [DATA_WIDTH-1:0]  index_in;
  logic                          index_valid_in;
  logic                          index_overflow_in;
  logic                          dump_ready_in;
  logic        [COUNT_WIDTH-1:0] dump_data_out;
  logic        [ADDR_WIDTH-1:0]  dump_addr_out;
  logic                          dump_valid_out;
  logic                          dump_last_out;

  modport master (
    output index_in, index_valid_in, index_overflow_in, dump_ready_in,
    input  dump_data_out, dump_addr_out, dump_valid_out, dump_last_out
  );

  modport slave (
    input  index_in, index_valid_in, index_overflow_in, dump_ready_in,
    output dump_data_out, dump_addr_out, dump_valid_out, dump_last_out
  );

endinterface

// File: rtl/bbox_bin_accumulator_bin_ram.sv
// Simple dual-port bin storage with a registered, enable-gated read port.
module bin_ram
  import bbox_bin_accumulator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bbox_bin_accumulator.sv
// Histogram of bin indices per frame; bins are streamed out and cleared after each frame.
module bbox_bin_accumulator
  import bbox_bin_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_done_in,
  output logic                   busy_out,
  output logic [COUNT_WIDTH-1:0] oor_count_out,
  output logic [COUNT_WIDTH-1:0] drop_count_out,
  bbox_bin_accumulator_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]  clr_ptr;
  logic                   s0_valid, s1_valid, fwd_valid;
  logic [ADDR_WIDTH-1:0]  s0_addr, s1_addr, fwd_addr;
  logic [COUNT_WIDTH-1:0] fwd_data, acc_base, acc_sum;
  logic [ADDR_WIDTH:0]    rd_ptr;
  logic                   rd_pend;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic                   out_free, rd_issue, last_hs;
  logic                   idx_in_range, idx_accept;

  logic                   ram_we, ram_re;
  logic [ADDR_WIDTH-1:0]  ram_wa, ram_ra;
  logic [COUNT_WIDTH-1:0] ram_wd, ram_rd;

  bin_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (COUNT_WIDTH)
  ) u_bin_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd),
    .rd_en   (ram_re),
    .rd_addr (ram_ra),
    .rd_data (ram_rd)
  );

  // Upper index bits all zero rejects both negative and >= DEPTH values.
  assign idx_in_range = !bus.index_overflow_in &&
                        (bus.index_in[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  assign idx_accept   = (state == ACCUM) && bus.index_valid_in && idx_in_range;

  // The read issued alongside the previous write returns stale data; patch it.
  assign acc_base = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : ram_rd;
  assign acc_sum  = (&acc_base) ? acc_base : acc_base + 1'b1;

  assign out_free = !bus.dump_valid_out || bus.dump_ready_in;
  assign rd_issue = (state == DUMP) && !rd_ptr[ADDR_WIDTH] && (!rd_pend || out_free);
  assign last_hs  = bus.dump_valid_out && bus.dump_ready_in && bus.dump_last_out;
  assign busy_out = (state != ACCUM);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wa     = s1_addr;
    ram_wd     = acc_sum;
    ram_re     = 1'b0;
    ram_ra     = s0_addr;
    unique case (state)
      CLEAR: begin
        ram_we = 1'b1;
        ram_wa = clr_ptr;
        ram_wd = '0;
        if (clr_ptr == LAST_ADDR) state_next = ACCUM;
      end
      ACCUM: begin
        ram_re = s0_valid;
        ram_we = s1_valid;
        if (frame_done_in) state_next = DRAIN;
      end
      DRAIN: begin
        ram_re = s0_valid;
        ram_we = s1_valid;
        if (!s0_valid && !s1_valid) state_next = DUMP;
      end
      DUMP: begin
        ram_re = rd_issue;
        ram_ra = rd_ptr[ADDR_WIDTH-1:0];
        // Clear a bin only once its read data has moved into the output beat.
        ram_we = rd_pend && out_free;
        ram_wa = rd_addr_q;
        ram_wd = '0;
        if (last_hs) state_next = ACCUM;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clr_ptr            <= '0;
      s0_valid           <= 1'b0;
      s0_addr            <= '0;
      s1_valid           <= 1'b0;
      s1_addr            <= '0;
      fwd_valid          <= 1'b0;
      fwd_addr           <= '0;
      fwd_data           <= '0;
      rd_ptr             <= '0;
      rd_pend            <= 1'b0;
      rd_addr_q          <= '0;
      bus.dump_valid_out <= 1'b0;
      bus.dump_last_out  <= 1'b0;
      bus.dump_data_out  <= '0;
      bus.dump_addr_out  <= '0;
      oor_count_out      <= '0;
      drop_count_out     <= '0;
    end else begin
      clr_ptr   <= (state == CLEAR) ? clr_ptr + 1'b1 : '0;
      s0_valid  <= idx_accept;
      s0_addr   <= bus.index_in[ADDR_WIDTH-1:0];
      s1_valid  <= s0_valid;
      s1_addr   <= s0_addr;
      fwd_valid <= s1_valid;
      fwd_addr  <= s1_addr;
      fwd_data  <= acc_sum;

      // Two-slot dump pipe: RAM output register holds a pending read, output regs hold the beat.
      if (state == DUMP) begin
        if (rd_issue) begin
          rd_ptr    <= rd_ptr + 1'b1;
          rd_addr_q <= rd_ptr[ADDR_WIDTH-1:0];
        end
        rd_pend <= rd_issue || (rd_pend && !out_free);
        if (out_free) begin
          bus.dump_valid_out <= rd_pend;
          if (rd_pend) begin
            bus.dump_data_out <= ram_rd;
            bus.dump_addr_out <= rd_addr_q;
            bus.dump_last_out <= (rd_addr_q == LAST_ADDR);
          end
        end
      end else begin
        rd_ptr             <= '0;
        rd_pend            <= 1'b0;
        bus.dump_valid_out <= 1'b0;
      end

      if ((state == DUMP) && last_hs)
        oor_count_out <= '0;
      else if ((state == ACCUM) && bus.index_valid_in && !idx_in_range && !(&oor_count_out))
        oor_count_out <= oor_count_out + 1'b1;

      if ((state != ACCUM) && bus.index_valid_in && !(&drop_count_out))
        drop_count_out <= drop_count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_bbox_bin_accumulator.sv
// Directed bench for bbox_bin_accumulator with a dump-beat scoreboard.
module tb_bbox_bin_accumulator;
  import bbox_bin_accumulator_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 256;
  localparam int CMAX  = 65535;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_done_in = 1'b0;
  logic          busy_out;
  logic [CW-1:0] oor_count_out;
  logic [CW-1:0] drop_count_out;

  bbox_bin_accumulator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  bbox_bin_accumulator #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_done_in  (frame_done_in),
    .busy_out       (busy_out),
    .oor_count_out  (oor_count_out),
    .drop_count_out (drop_count_out),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [24:0] exp_q[$];
  int  exp_bins[DEPTH];
  int  exp_oor = 0;
  int  exp_drop = 0;
  bit  tb_accum = 1'b0;
  bit  rand_ready = 1'b0;
  int  frame_beats = 0;
  int  first_beat_cyc = 0;
  int  last_beat_cyc = 0;
  int  fd_cyc = 0;
  bit  stalled = 1'b0;
  logic [24:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard on every accepted beat, checks hold during stalls.
  always @(negedge clk) begin
    logic [24:0] beat;
    beat = {bus.dump_last_out, bus.dump_addr_out, bus.dump_data_out};
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(bus.dump_valid_out), 64'd1);
        check("stall_hold", 64'(beat), 64'(held));
      end
      if (bus.dump_valid_out && bus.dump_ready_in) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed addr=%0d expected no beat", bus.dump_addr_out);
        end
        if (exp_q.size() > 0) check("beat", 64'(beat), 64'(exp_q.pop_front()));
        if (frame_beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        frame_beats++;
        stalled = 1'b0;
      end else if (bus.dump_valid_out) begin
        stalled = 1'b1;
        held    = beat;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.dump_ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic model(input int idx, input bit ovf);
    if (!tb_accum) begin
      if (exp_drop < CMAX) exp_drop++;
    end else if (!ovf && idx >= 0 && idx < DEPTH) begin
      if (exp_bins[idx] < CMAX) exp_bins[idx]++;
    end else if (exp_oor < CMAX) begin
      exp_oor++;
    end
  endtask

  task automatic send(input int idx, input bit ovf);
    bus.index_in          = 16'(idx);
    bus.index_valid_in    = 1'b1;
    bus.index_overflow_in = ovf;
    model(idx, ovf);
    tick();
    bus.index_valid_in    = 1'b0;
    bus.index_overflow_in = 1'b0;
  endtask

  task automatic start_frame(input bit with_idx, input int idx, input bit rnd);
    if (with_idx) begin
      bus.index_in          = 16'(idx);
      bus.index_valid_in    = 1'b1;
      bus.index_overflow_in = 1'b0;
      model(idx, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({1'(i == DEPTH - 1), 8'(i), 16'(exp_bins[i])});
    frame_beats   = 0;
    frame_done_in = 1'b1;
    tb_accum      = 1'b0;
    rand_ready    = rnd;
    tick();
    fd_cyc             = cyc;
    frame_done_in      = 1'b0;
    bus.index_valid_in = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input bit chk_timing);
    for (int n = 0; n < 4000 && exp_q.size() != 0; n++) tick();
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rand_ready        = 1'b0;
    bus.dump_ready_in = 1'b1;
    tick();
    tb_accum = 1'b1;
    check({tag, "_busy_after"}, 64'(busy_out), 64'd0);
    check({tag, "_valid_after"}, 64'(bus.dump_valid_out), 64'd0);
    check({tag, "_oor_after"}, 64'(oor_count_out), 64'd0);
    check({tag, "_drop"}, 64'(drop_count_out), 64'(exp_drop));
    if (chk_timing) begin
      check({tag, "_throughput"}, 64'(last_beat_cyc - first_beat_cyc), 64'(DEPTH - 1));
      check({tag, "_first_latency_ok"}, 64'((first_beat_cyc - fd_cyc) <= 6), 64'd1);
    end
    for (int i = 0; i < DEPTH; i++) exp_bins[i] = 0;
    exp_oor = 0;
  endtask

  initial begin
    bus.index_in          = '0;
    bus.index_valid_in    = 1'b0;
    bus.index_overflow_in = 1'b0;
    bus.dump_ready_in     = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_bins[i] = 0;

    // Reset values
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy_out), 64'd1);
    check("rst_valid", 64'(bus.dump_valid_out), 64'd0);
    check("rst_last", 64'(bus.dump_last_out), 64'd0);
    check("rst_data", 64'(bus.dump_data_out), 64'd0);
    check("rst_addr", 64'(bus.dump_addr_out), 64'd0);
    check("rst_oor", 64'(oor_count_out), 64'd0);
    check("rst_drop", 64'(drop_count_out), 64'd0);
    reset_n = 1'b1;
    repeat (DEPTH + 2) tick();
    check("clear_done_busy", 64'(busy_out), 64'd0);
    tb_accum = 1'b1;

    // Empty frame: all-zero dump at full rate
    start_frame(1'b0, 0, 1'b0);
    finish_frame("empty", 1'b1);

    // Repeated hits; last index arrives with frame_done
    repeat (4) send(5, 1'b0);
    start_frame(1'b1, 7, 1'b0);
    finish_frame("hits57", 1'b1);

    // Alternating addresses, back-to-back and one apart
    send(3, 1'b0); send(9, 1'b0); send(3, 1'b0); send(9, 1'b0); send(3, 1'b0);
    start_frame(1'b0, 0, 1'b0);
    finish_frame("alt39", 1'b0);

    // Out-of-range and overflow indices
    send(-1, 1'b0); send(256, 1'b0); send(10, 1'b1);
    check("oor_count", 64'(oor_count_out), 64'(exp_oor));
    check("oor_drop", 64'(drop_count_out), 64'd0);
    start_frame(1'b0, 0, 1'b0);
    finish_frame("oor", 1'b0);

    // Random ready stalls; indices sent mid-dump are dropped
    send(1, 1'b0); send(2, 1'b0); send(2, 1'b0); send(200, 1'b0); send(255, 1'b0);
    start_frame(1'b0, 0, 1'b1);
    for (int n = 0; n < 2000 && frame_beats < 10; n++) tick();
    check("mid_dump_reached", 64'(frame_beats >= 10), 64'd1);
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(300, 1'b0);
    finish_frame("stall", 1'b0);
    check("drop_count4", 64'(drop_count_out), 64'd4);

    // Reset in the middle of a dump
    repeat (3) send(200, 1'b0);
    start_frame(1'b0, 0, 1'b0);
    for (int n = 0; n < 2000 && frame_beats < 100; n++) tick();
    check("beat100_reached", 64'(frame_beats), 64'd100);
    reset_n = 1'b0;
    tick();
    check("midrst_valid", 64'(bus.dump_valid_out), 64'd0);
    check("midrst_busy", 64'(busy_out), 64'd1);
    check("midrst_drop", 64'(drop_count_out), 64'd0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_bins[i] = 0;
    exp_oor  = 0;
    exp_drop = 0;
    tb_accum = 1'b0;
    reset_n  = 1'b1;
    send(50, 1'b0);
    repeat (DEPTH + 2) tick();
    tb_accum = 1'b1;
    check("reclear_busy", 64'(busy_out), 64'd0);
    check("reclear_valid", 64'(bus.dump_valid_out), 64'd0);
    check("clear_drop", 64'(drop_count_out), 64'(exp_drop));
    send(200, 1'b0);
    start_frame(1'b0, 0, 1'b0);
    finish_frame("post_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
